// File: rtl/cpa_pkg.sv
// Shared types and slice geometry for the pipelined final carry-propagate adder.
package cpa_pkg;

  localparam int CPA_WIDTH = 9;
  localparam int CPA_SEG   = 4;

  // Every stage carries the full-width vectors; each stage only rewrites its own slice.
  typedef struct packed {
    logic                 valid;
    logic [CPA_WIDTH:1]   res;
    logic [CPA_WIDTH:1]   sum;
    logic [CPA_WIDTH:1]   carry;
    logic                 c;
  } cpa_stage_t;

  function automatic int cpa_nstage(input int w, input int s);
    return (w + s - 1) / s;
  endfunction

  function automatic int cpa_slice_lo(input int k, input int s);
    return (k - 1) * s + 1;
  endfunction

  function automatic int cpa_slice_hi(input int k, input int s, input int w);
    return (k * s < w) ? k * s : w;
  endfunction

endpackage

// File: rtl/csa_final_cpa_pipe_if.sv
// Operand/result handshake bundle; slave is the adder side, master the environment.
interface csa_final_cpa_pipe_if
  import cpa_pkg::*;
#(
  parameter int WIDTH = CPA_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:1]   in_sum;
  logic [WIDTH:1]   in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:1]   out_result;
  logic             out_cout;

  modport slave (
    input  in_valid, in_sum, in_carry, out_ready,
    output in_ready, out_valid, out_result, out_cout
  );

  modport master (
    output in_valid, in_sum, in_carry, out_ready,
    input  in_ready, out_valid, out_result, out_cout
  );
endinterface

// File: rtl/csa_final_cpa_seg.sv
// One registered slice of the carry-propagate adder. Define CSA_FINAL_CPA_SAT_EN to
// saturate the result to all ones in the final slice when its carry out is set.
module csa_final_cpa_seg
  import cpa_pkg::*;
#(
  parameter int WIDTH = CPA_WIDTH,
  parameter int SEG   = CPA_SEG,
  parameter int K     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  cpa_stage_t prev_i,
  input  logic       ready_i,
  output logic       ready_o,
  output cpa_stage_t stage_o
);
  localparam int LO = cpa_slice_lo(K, SEG);
  localparam int HI = cpa_slice_hi(K, SEG, WIDTH);
  localparam int WS = HI - LO + 1;

  cpa_stage_t  stage_q;
  cpa_stage_t  stage_d;
  logic [WS:0] slice_sum;

  assign slice_sum = {1'b0, prev_i.sum[HI:LO]} + {1'b0, prev_i.carry[HI:LO]}
                   + {{WS{1'b0}}, prev_i.c};

  always_comb begin
    stage_d            = prev_i;
    stage_d.res[HI:LO] = slice_sum[WS-1:0];
    stage_d.c          = slice_sum[WS];
`ifdef CSA_FINAL_CPA_SAT_EN
    if ((HI == WIDTH) && slice_sum[WS]) begin
      stage_d.res = '1;
    end
`endif
  end

  assign ready_o = !stage_q.valid || ready_i;

  // A bubble load is harmless: the invalid contents are never presented downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else if (ready_o) begin
      stage_q <= stage_d;
    end
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/csa_final_cpa_pipe.sv
// Pipelined carry-propagate adder resolving a carry-save pair, SEG bits per stage.
// Optional macro CSA_FINAL_CPA_SAT_EN saturates out_result when the final carry is set.
module csa_final_cpa_pipe
  import cpa_pkg::*;
#(
  parameter int WIDTH = CPA_WIDTH,
  parameter int SEG   = CPA_SEG
) (
  input  logic                 clk,
  input  logic                 rst,
  csa_final_cpa_pipe_if.slave  bus
);
  localparam int NSTAGE = cpa_nstage(WIDTH, SEG);

  cpa_stage_t       st [0:NSTAGE];
  logic [NSTAGE:1]  vld;
  logic [NSTAGE:1]  rdy;
  logic             unused_sink;

  always_comb begin
    st[0]       = '0;
    st[0].valid = bus.in_valid;
    st[0].sum   = bus.in_sum;
    st[0].carry = bus.in_carry;
  end

  genvar gi;
  generate
    for (gi = 1; gi <= NSTAGE; gi++) begin : g_stage
      logic down_rdy;

      // Downstream ready flattened from the valid bits so no ready bit feeds another.
      if (gi == NSTAGE) begin : g_last
        assign down_rdy = bus.out_ready;
      end else begin : g_mid
        assign down_rdy = bus.out_ready || !(&vld[NSTAGE:gi+1]);
      end

      csa_final_cpa_seg #(
        .WIDTH (WIDTH),
        .SEG   (SEG),
        .K     (gi)
      ) u_seg (
        .clk     (clk),
        .rst     (rst),
        .prev_i  (st[gi-1]),
        .ready_i (down_rdy),
        .ready_o (rdy[gi]),
        .stage_o (st[gi])
      );

      assign vld[gi] = st[gi].valid;
    end
  endgenerate

  assign bus.in_ready   = rdy[1];
  assign bus.out_valid  = st[NSTAGE].valid;
  assign bus.out_result = st[NSTAGE].res;
  assign bus.out_cout   = st[NSTAGE].c;

  assign unused_sink = ^{st[NSTAGE].sum, st[NSTAGE].carry, rdy, vld};

endmodule

// File: tb/tb_csa_final_cpa_pipe.sv
// Scoreboard bench for csa_final_cpa_pipe: driver pushes expectations, monitor pops on transfer.
module tb_csa_final_cpa_pipe;
  localparam int W = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csa_final_cpa_pipe_if #(.WIDTH(W)) bus ();

  csa_final_cpa_pipe #(.WIDTH(W), .SEG(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W:0] val;
    int         t;
    bit         lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   run_len = 0;
  int   max_run = 0;

  // Directed vectors; expected value is {cout, result}.
  logic [W:1] ds [8] = '{9'h0AA, 9'h1FF, 9'h100, 9'h00F, 9'h0F0, 9'h0FF, 9'h001, 9'h1FF};
  logic [W:1] dc [8] = '{9'h055, 9'h001, 9'h100, 9'h001, 9'h010, 9'h0FF, 9'h001, 9'h1FF};
`ifdef CSA_FINAL_CPA_SAT_EN
  logic [W:0] de [8] = '{10'h0FF, 10'h3FF, 10'h3FF, 10'h010, 10'h100, 10'h1FE, 10'h002, 10'h3FF};
`else
  logic [W:0] de [8] = '{10'h0FF, 10'h200, 10'h200, 10'h010, 10'h100, 10'h1FE, 10'h002, 10'h3FE};
`endif

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_total++;
    if (got === req) n_pass++;
    else $display("FAIL %s: got=0x%0h required=0x%0h", name, got, req);
  endfunction

  function automatic logic [W:0] model(input logic [W:1] s, input logic [W:1] c);
    logic [W:0] f;
    f = {1'b0, s} + {1'b0, c};
`ifdef CSA_FINAL_CPA_SAT_EN
    if (f[W]) f[W-1:0] = '1;
`endif
    return f;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      run_len = 0;
    end else if (bus.out_valid && bus.out_ready) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got=0x%0h required=none", {bus.out_cout, bus.out_result});
      end else begin
        e = exp_q.pop_front();
        $display("xfer cyc=%0d result=0x%03h cout=%0b", cyc, bus.out_result, bus.out_cout);
        chk("result", {22'd0, bus.out_cout, bus.out_result}, {22'd0, e.val});
        if (e.lat) chk("latency", cyc - e.t, 3);
      end
    end else begin
      run_len = 0;
    end
  end

  task automatic send(input logic [W:1] s, input logic [W:1] c, input logic [W:0] e,
                      input bit lat_en, output int tries);
    bit ok;
    ok = 1'b0;
    tries = 0;
    bus.in_valid = 1'b1;
    bus.in_sum   = s;
    bus.in_carry = c;
    while (!ok && tries < 20) begin
      tries++;
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        exp_q.push_back('{val: e, t: cyc, lat: lat_en});
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_total++;
      $display("FAIL accept_timeout: got=in_ready low for 20 cycles required=accept");
    end
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin : main
    int         tries;
    logic [W:1] s;
    logic [W:1] c;

    bus.in_valid  = 1'b0;
    bus.in_sum    = '0;
    bus.in_carry  = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_result", bus.out_result, 0);
    chk("reset_out_cout", bus.out_cout, 0);
    chk("reset_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors back to back, latency checked on each.
    for (int i = 0; i < 8; i++) begin
      send(ds[i], dc[i], de[i], 1'b1, tries);
      chk("dir_accept", tries, 1);
    end
    drain();

    // Backpressure: out_ready low, only three items fit.
    bus.out_ready = 1'b0;
    send(9'h011, 9'h001, 10'h012, 1'b0, tries); chk("bp_accept1", tries, 1);
    send(9'h022, 9'h001, 10'h023, 1'b0, tries); chk("bp_accept2", tries, 1);
    send(9'h033, 9'h001, 10'h034, 1'b0, tries); chk("bp_accept3", tries, 1);
    bus.in_valid = 1'b1;
    bus.in_sum   = 9'h044;
    bus.in_carry = 9'h001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", bus.in_ready, 0);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_held_result", {bus.out_cout, bus.out_result}, 10'h012);
      @(posedge clk);
      #1;
    end
    max_run = 0;
    bus.out_ready = 1'b1;
    send(9'h044, 9'h001, 10'h045, 1'b0, tries); chk("bp_release_accept", tries, 1);
    send(9'h055, 9'h001, 10'h056, 1'b0, tries); chk("bp_accept5", tries, 1);
    drain();
    chk("bp_drain_run", max_run, 5);

    // Throughput: 16 random pairs back to back.
    max_run = 0;
    for (int i = 0; i < 16; i++) begin
      s = 9'($urandom_range(0, 511));
      c = 9'($urandom_range(0, 511));
      send(s, c, model(s, c), 1'b1, tries);
      chk("tp_in_ready", tries, 1);
    end
    drain();
    chk("tp_run", max_run, 16);

    // Reset with three items in flight: none may ever emerge.
    bus.out_ready = 1'b0;
    send(9'h0AA, 9'h055, 10'h0FF, 1'b0, tries);
    send(9'h001, 9'h002, 10'h003, 1'b0, tries);
    send(9'h003, 9'h004, 10'h007, 1'b0, tries);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", bus.out_valid, 0);
    chk("post_rst_out_result", bus.out_result, 0);
    chk("post_rst_out_cout", bus.out_cout, 0);
    repeat (10) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got=simulation still running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/csa_final_cpa_pipe.md
Name: csa_final_cpa_pipe

Overview:
- Pipelined carry-propagate adder placed directly downstream of the 3:2 carry-save compressor in the multiplier/MAC datapath.
- Takes the redundant sum/carry pair, resolves it into a single binary result, one SEG-bit slice per pipeline stage.
- Uses valid/ready handshakes on both sides so the GEMV datapath can stall it.
- Unsigned arithmetic throughout.

Parameters:
- WIDTH, 9, operand width; matches the compressor's S and Cout vectors, both indexed [WIDTH:1].
- SEG, 4, bits resolved per stage; 1 <= SEG <= WIDTH.
- NSTAGE (localparam), ceil(WIDTH/SEG), pipeline depth and latency; 3 at the defaults.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, in_sum/in_carry hold a valid operand pair.
- in_ready, output, 1, stage 1 can accept this cycle.
- in_sum, input, WIDTH [WIDTH:1], redundant sum vector (compressor S).
- in_carry, input, WIDTH [WIDTH:1], redundant carry vector (compressor Cout; bit 1 is normally 0, but it is added without any assumption).
- out_valid, output, 1, out_result/out_cout are valid.
- out_ready, input, 1, consumer accepts this cycle.
- out_result, output, WIDTH [WIDTH:1], in_sum + in_carry modulo 2^WIDTH.
- out_cout, output, 1, carry out of bit WIDTH.

Behaviour:
- Reset:
  - Asynchronous on rst=1: all stage valid bits clear, so out_valid=0.
  - out_result and out_cout reset to 0; data registers reset to 0.
  - Asserting rst mid-operation discards all in-flight items; no partial output appears after reset releases.
- Stage k (1..NSTAGE) holds:
  - v_k, its valid bit.
  - The resolved low result bits [(k*SEG) min WIDTH : 1].
  - The unresolved upper sum/carry bits.
  - The carry c_k out of the resolved slice.
- Stage k adds slice k of sum and carry plus c_(k-1), with c_0 = 0. The last slice is WIDTH - (NSTAGE-1)*SEG bits wide; at the defaults that is bit 9 alone.
- Flow control:
  - ready_k = !v_k || ready_(k+1), with ready_(NSTAGE+1) = out_ready.
  - in_ready = ready_1, computed combinationally; there is no combinational path from in_valid to in_ready.
  - A stage loads when ready_k=1.
  - The load is a bubble if stage k-1 is invalid, or if in_valid=0 for stage 1.
- Output side:
  - out_valid = v_NSTAGE.
  - out_result and out_cout come straight from the last stage's registers.
- Latency and throughput:
  - With out_ready held at 1: an item accepted in cycle t appears with out_valid=1 in cycle t+NSTAGE.
  - Full throughput: one result per cycle.
- Backpressure:
  - out_ready=0 with out_valid=1 holds out_result/out_cout stable.
  - Upstream stages keep filling bubbles.
  - in_ready falls only when all NSTAGE stages are valid.
- Simultaneous accept and issue: when the pipe is full and out_ready=1, the pipe shifts and accepts a new item in the same cycle with no lost cycle.
- Ordering: strict FIFO, no reordering.

Optional Feature:
- Macro: CSA_FINAL_CPA_SAT_EN.
- Defined:
  - When the final carry out is 1, out_result = all ones (2^WIDTH - 1).
  - out_cout still reports the raw carry, so saturation events stay visible.
  - Saturation is applied in the last stage; latency is unchanged.
- Undefined: out_result is the wrapped modulo-2^WIDTH sum.

Decomposition:
- Shared package cpa_pkg holds:
  - A function returning NSTAGE for (WIDTH, SEG).
  - Slice lower/upper bound functions.
  - A packed-struct typedef per stage: valid, low result, upper sum, upper carry, carry.
- One natural sub-module: csa_final_cpa_seg, a single registered slice stage with its own handshake.
  - The top instantiates it NSTAGE times in a generate loop.
  - The last instance is configured for the short slice.

Test Plan:
- Reset: assert rst mid-stream with 3 items in flight; release -> out_valid=0 and out_result=0; none of the 3 items is ever issued.
- Basic add: sum=0x0AA, carry=0x055, out_ready=1 -> 3 cycles later out_result=0x0FF, out_cout=0.
- Full carry ripple across all slices: sum=0x1FF, carry=0x001 -> out_result=0x000, out_cout=1.
  - With CSA_FINAL_CPA_SAT_EN: out_result=0x1FF, out_cout=1.
- Top-bit carry: sum=0x100, carry=0x100 -> out_result=0x000, out_cout=1.
  - With CSA_FINAL_CPA_SAT_EN: out_result=0x1FF.
- Backpressure: hold out_ready=0 and stream 5 items -> exactly 3 items are accepted, then in_ready=0.
  - The held out_result stays stable.
  - Releasing out_ready drains the items in order, one per cycle.
- Throughput: send 16 random back-to-back pairs with out_ready=1 -> in_ready stays 1; 16 consecutive out_valid cycles.
  - Every result equals sum+carry in WIDTH+1 bits, checked against a scoreboard.
